// File: rtl/inst_mem_sync.sv
// Synchronous-read instruction memory for the IF stage, loaded at run time and zeroed by a clear sweep.
// Define INST_MEM_PARITY_EN to store an even-parity bit per word and report it on par_err.
module inst_mem_sync #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       ADDR_W   = 6,
   parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] inst,
   output logic              inst_valid,
   output logic              busy,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic              prog_ack,
   output logic              par_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef INST_MEM_PARITY_EN
   localparam int unsigned MEM_W = DATA_W + 1;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif

   typedef enum logic {StClear, StRun} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                prog_ack_q, prog_ack_d;
   logic [DATA_W-1:0]   inst_q;
   logic                valid_q, valid_d;
   logic                fetch_load, inst_kill;

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [MEM_W-1:0]    mem_wword;
   logic [MEM_W-1:0]    rd_word;
   logic [MEM_W-1:0]    mem [DEPTH];

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      prog_ack_d = 1'b0;
      valid_d    = valid_q;
      fetch_load = 1'b0;
      inst_kill  = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = clr_cnt_q;
      mem_wdata  = NOP_WORD;
      unique case (state_q)
         StClear: begin
            // Sweep owns the write port; fetches and program writes are dropped.
            mem_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            valid_d   = 1'b0;
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (prog_we && !rst) begin
               mem_we    = 1'b1;
               mem_waddr = prog_addr;
               mem_wdata = prog_data;
            end
            prog_ack_d = prog_we;
            if (flush) begin
               inst_kill = 1'b1;
               valid_d   = 1'b0;
            end else if (stall) begin
               valid_d = valid_q;
            end else if (fetch_req) begin
               fetch_load = 1'b1;
               valid_d    = 1'b1;
            end else begin
               valid_d = 1'b0;
            end
         end
         default: state_d = StClear;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StClear;
         clr_cnt_q  <= '0;
         prog_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         prog_ack_q <= prog_ack_d;
      end
   end

`ifdef INST_MEM_PARITY_EN
   assign mem_wword = {^mem_wdata, mem_wdata};
`else
   assign mem_wword = mem_wdata;
`endif

   // Single write port, no reset: keeps the array inferable as block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wword;
      end
   end

   // Read and write at the same edge: nonblocking update yields the old word.
   assign rd_word = mem[fetch_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q  <= NOP_WORD;
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (inst_kill) begin
            inst_q <= NOP_WORD;
         end else if (fetch_load) begin
            inst_q <= rd_word[DATA_W-1:0];
         end
      end
   end

`ifdef INST_MEM_PARITY_EN
   logic par_q;

   // Parity tracks inst_valid: cleared whenever valid drops, held on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_q <= 1'b0;
      end else if (!valid_d) begin
         par_q <= 1'b0;
      end else if (fetch_load) begin
         par_q <= rd_word[DATA_W] ^ (^rd_word[DATA_W-1:0]);
      end
   end

   assign par_err = par_q;
`else
   assign par_err = 1'b0;
`endif

   assign inst       = inst_q;
   assign inst_valid = valid_q;
   assign busy       = (state_q == StClear);
   assign prog_ack   = prog_ack_q;

`ifndef SYNTHESIS
   a_busy_no_valid: assert property (@(posedge clk) disable iff (rst) busy |-> !inst_valid);
   a_ack_after_we:  assert property (@(posedge clk) disable iff (rst) prog_ack |-> $past(prog_we));
`endif

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
- Parametrised successor to the fixed 64x32 combinational instruction ROM.
- Synchronous-read instruction memory for the IF stage of the pipeline CPU, with a fetch handshake that honours pipeline stall and flush.
- Has a program-load write port, so test programs are loaded at run time instead of being hard-coded.
- Contents are zeroed by a clear sweep after reset, so unloaded words read as NOP.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words.
- NOP_WORD, 32'h00000000, value driven on inst after flush or reset; also the clear-sweep fill value.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  IF requests the word at fetch_addr.
- fetch_addr  in  ADDR_W  word address (PC[ADDR_W+1:2] supplied by IF).
- stall  in  1  pipeline stall; hold the current output.
- flush  in  1  branch/jump flush; kill the current output.
- inst  out  DATA_W  fetched instruction (registered).
- inst_valid  out  1  inst is a live fetch result.
- busy  out  1  clear sweep in progress; fetches are ignored.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  ADDR_W  program-load word address.
- prog_data  in  DATA_W  program-load data.
- prog_ack  out  1  one-cycle pulse, one cycle after an accepted write.
- par_err  out  1  parity error on the current fetch (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state <= CLEAR, clr_cnt <= 0.
  - inst <= NOP_WORD, inst_valid <= 0, busy <= 1, prog_ack <= 0, par_err <= 0.
  - Reset in any state, including mid-load or mid-fetch, restarts the clear sweep. All contents are lost.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes NOP_WORD to mem[clr_cnt] and increments clr_cnt.
  - CLEAR exits when clr_cnt == DEPTH-1 has been written. The next state is RUN and busy <= 0, so busy is high for exactly DEPTH cycles after reset is released.
  - CLEAR: fetch_req and prog_we are ignored. prog_ack stays 0, inst_valid stays 0, inst holds NOP_WORD.
  - RUN: remains in RUN until rst.
- Fetch (RUN only), priority flush > stall > fetch_req:
  - flush=1: inst <= NOP_WORD, inst_valid <= 0.
  - else stall=1: inst and inst_valid hold; fetch_addr is not sampled.
  - else fetch_req=1: inst <= mem[fetch_addr], inst_valid <= 1. Latency is 1 cycle from the request edge.
  - else: inst_valid <= 0, inst holds its last value.
- Program write (RUN only):
  - prog_we=1: mem[prog_addr] <= prog_data at the edge; prog_ack=1 in the following cycle only.
  - Back-to-back writes are accepted every cycle, with a matching ack each cycle.
- Same-cycle fetch and write to the same address: the fetch returns the OLD word (read-before-write). The new word is visible from the next fetch onward.
- Addresses wrap naturally because DEPTH = 2**ADDR_W. There is no out-of-range case.
- Memory is a single array: DEPTH x DATA_W, plus 1 parity bit when the optional feature is enabled. It is inferable as block RAM: one write port, one synchronous read port. The clear sweep and program write share the write port, and are mutually exclusive by state.

Optional Feature:
- Macro: INST_MEM_PARITY_EN.
- Enabled:
  - Each word stores an even-parity bit computed on every write (sweep or program).
  - On a fetch, par_err <= (stored parity != ^read data), registered alongside inst_valid.
  - par_err follows inst_valid hold/clear rules: it holds on stall and clears on flush or reset.
- Disabled: no parity storage; par_err is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, then hold rst=0 with fetch_req=1 at addr 0x05. Required: busy=1 for exactly 64 cycles (ADDR_W=6), inst_valid=0 throughout. First fetch after busy falls returns 32'h00000000 with inst_valid=1 one cycle later.
2. After the sweep, write 0x38001c63 to addr 0x01 and 0x340014aa to addr 0x02 on consecutive cycles. Required: prog_ack pulses on each of the two following cycles. Fetches at 0x01 then 0x02 return those words with 1-cycle latency.
3. Fetch at 0x01, then hold stall=1 for 3 cycles while fetch_addr=0x02. Required: inst stays 0x38001c63 and inst_valid=1 during the stall. Releasing stall returns 0x340014aa next cycle.
4. flush=1 together with stall=1 and fetch_req=1. Required: inst=0x00000000, inst_valid=0 next cycle.
5. Same-cycle prog_we to 0x0e with 0x08308401 and fetch at 0x0e holding 0. Required: the fetch returns 0x00000000; the next fetch of 0x0e returns 0x08308401.
6. With INST_MEM_PARITY_EN, force-flip one stored bit at addr 0x03, then fetch 0x03. Required: par_err=1 with inst_valid=1. Fetching a clean address returns par_err=0. Asserting rst mid-sequence clears par_err and restarts the 64-cycle sweep.
